// File: rtl/bsr_ctrl_pkg.sv
// Shared encodings for the bidirectional shift-register controller:
// command opcodes, FSM states and the default register width.
package bsr_ctrl_pkg;

  localparam int BSR_N_DEFAULT = 4;

  typedef enum logic [1:0] {
    OP_SHIFT  = 2'b00,
    OP_LOAD   = 2'b01,
    OP_ROTATE = 2'b10,
    OP_RSV    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } state_e;

  // Step counter must hold both the 4-bit command count and N for LOAD.
  function automatic int cnt_width(input int n);
    int w;
    w = 4;
    while ((32'sd1 <<< w) <= n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bsr_step_cnt.sv
// Step down-counter: parallel load, saturating decrement, zero flag.
module bsr_step_cnt #(
  parameter int CW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic [CW-1:0] o_count,
  output logic          o_zero
);

  logic [CW-1:0] r_cnt;

  // Load has priority; decrement stops at zero so the count never wraps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != {CW{1'b0}})) begin
      r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_count = r_cnt;
  assign o_zero  = (r_cnt == {CW{1'b0}});

endmodule

// File: rtl/bsr_ctrl.sv
// Command FSM driving serial-in, direction and enable of an external
// N-bit bidirectional shift register (SHIFT / LOAD / ROTATE).
module bsr_ctrl
  import bsr_ctrl_pkg::*;
#(
  parameter int N = BSR_N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic         cmd_dir,
  input  logic [3:0]   cmd_cnt,
  input  logic         cmd_fill,
  input  logic [N-1:0] cmd_data,
  input  logic [N-1:0] sr_q,
  output logic         sr_m,
  output logic         sr_dir,
  output logic         sr_en,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int CW = cnt_width(N);

  state_e        r_state;
  op_e           r_op;
  logic          r_dir;
  logic          r_fill;
  logic [N-1:0]  r_data;
  logic          r_sr_en;
  logic          r_sr_dir;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic          w_start_acc;
  logic [CW-1:0] w_step_cnt;
  logic          w_cnt_dec;
  logic [CW-1:0] w_cnt;
  logic          w_cnt_zero;
  logic          w_last;
  logic [CW-1:0] w_idx;
  logic          w_load_bit;
  logic          w_sr_m;

  assign w_start_acc = (r_state == ST_IDLE) && start;
  assign w_cnt_dec   = (r_state == ST_RUN) && !w_cnt_zero;
  assign w_last      = (w_cnt == {{(CW-1){1'b0}}, 1'b1});

  // Step count for the incoming command; reserved op takes the zero path.
  always_comb begin
    w_step_cnt = {CW{1'b0}};
    case (op_e'(op))
      OP_SHIFT:  w_step_cnt = CW'(cmd_cnt);
      OP_LOAD:   w_step_cnt = CW'(N);
      OP_ROTATE: w_step_cnt = CW'(cmd_cnt);
      default:   w_step_cnt = {CW{1'b0}};
    endcase
  end

  bsr_step_cnt #(
    .CW(CW)
  ) u_step_cnt (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_load     (w_start_acc),
    .i_load_val (w_step_cnt),
    .i_dec      (w_cnt_dec),
    .o_count    (w_cnt),
    .o_zero     (w_cnt_zero)
  );

  // Remaining count c maps to step i = N-c: dir=1 feeds data[c-1], dir=0 data[N-c].
  always_comb begin
    w_idx      = r_dir ? (w_cnt - {{(CW-1){1'b0}}, 1'b1}) : (CW'(N) - w_cnt);
    w_load_bit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_idx == CW'(i)) begin
        w_load_bit = r_data[i];
      end else begin
        w_load_bit = w_load_bit;
      end
    end
  end

  // Serial-in bit; ROTATE feeds back the outgoing end of sr_q without delay.
  always_comb begin
    w_sr_m = 1'b0;
    if (r_state == ST_RUN) begin
      case (r_op)
        OP_SHIFT:  w_sr_m = r_fill;
        OP_LOAD:   w_sr_m = w_load_bit;
        OP_ROTATE: w_sr_m = r_dir ? sr_q[N-1] : sr_q[0];
        default:   w_sr_m = 1'b0;
      endcase
    end else begin
      w_sr_m = 1'b0;
    end
  end

  // Command FSM with registered status and shift-register controls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_SHIFT;
      r_dir    <= 1'b0;
      r_fill   <= 1'b0;
      r_data   <= {N{1'b0}};
      r_sr_en  <= 1'b0;
      r_sr_dir <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op     <= op_e'(op);
            r_dir    <= cmd_dir;
            r_fill   <= cmd_fill;
            r_data   <= cmd_data;
            r_sr_dir <= cmd_dir;
            r_busy   <= 1'b1;
            if (w_step_cnt != {CW{1'b0}}) begin
              r_state <= ST_RUN;
              r_sr_en <= 1'b1;
            end else begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
              r_err   <= (op_e'(op) == OP_RSV);
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (w_last) begin
            r_state <= ST_FIN;
            r_sr_en <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b0;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_FIN: begin
          r_state  <= ST_IDLE;
          r_sr_dir <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
          r_err    <= 1'b0;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_sr_en  <= 1'b0;
          r_sr_dir <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
          r_err    <= 1'b0;
        end
      endcase
    end
  end

  assign sr_m   = w_sr_m;
  assign sr_dir = r_sr_dir;
  assign sr_en  = r_sr_en;
  assign busy   = r_busy;
  assign done   = r_done;
  assign err    = r_err;

endmodule

// File: tb/tb_bsr_ctrl.sv
// Directed bench: a behavioural 4-bit shift register closes the loop
// through sr_m/sr_dir/sr_en -> sr_q; vectors plus multi-cycle sequences.
module tb_bsr_ctrl;

  typedef struct {
    logic [1:0] op;
    logic       dir;
    logic [3:0] cnt;
    logic       fill;
    logic [3:0] data;
    logic [3:0] init_q;
    logic [3:0] exp_q;
    int         exp_sh;
    logic       exp_err;
    logic       chk_m;
    logic [3:0] exp_m;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic       cmd_dir;
  logic [3:0] cmd_cnt;
  logic       cmd_fill;
  logic [3:0] cmd_data;
  logic [3:0] q;
  logic       sr_m, sr_dir, sr_en, busy, done, err;

  logic       q_load;
  logic [3:0] q_init;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t vecs[11];

  bsr_ctrl #(.N(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .cmd_dir  (cmd_dir),
    .cmd_cnt  (cmd_cnt),
    .cmd_fill (cmd_fill),
    .cmd_data (cmd_data),
    .sr_q     (q),
    .sr_m     (sr_m),
    .sr_dir   (sr_dir),
    .sr_en    (sr_en),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference shift register: dir=1 shifts toward MSB taking sr_m at LSB.
  always @(posedge clk) begin
    if (q_load) q <= q_init;
    else if (sr_en) q <= sr_dir ? {q[2:0], sr_m} : {sr_m, q[3:1]};
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic preset_q(input logic [3:0] v);
    @(negedge clk);
    q_init = v;
    q_load = 1'b1;
    @(negedge clk);
    q_load = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int sh, dc, bc;
    logic es;
    logic [3:0] ms;
    string tag;
    tag = $sformatf("v%0d", idx);
    preset_q(v.init_q);
    op = v.op; cmd_dir = v.dir; cmd_cnt = v.cnt; cmd_fill = v.fill; cmd_data = v.data;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    sh = 0; dc = 0; bc = 0; es = 1'b0; ms = 4'b0000;
    for (int cyc = 1; cyc <= 40 && dc == 0; cyc++) begin
      @(negedge clk);
      if (busy) bc++;
      if (sr_en) begin
        sh++;
        ms = {ms[2:0], sr_m};
        if (sh == 1) chk({tag, "_sr_dir"}, int'(sr_dir), int'(v.dir));
      end
      if (done) begin
        dc = cyc;
        es = err;
        chk({tag, "_q_at_done"}, int'(q), int'(v.exp_q));
      end
    end
    chk({tag, "_shifts"}, sh, v.exp_sh);
    chk({tag, "_done_cycle"}, dc, v.exp_sh + 1);
    chk({tag, "_err"}, int'(es), int'(v.exp_err));
    chk({tag, "_busy_cycles"}, bc, v.exp_sh + 1);
    if (v.chk_m) chk({tag, "_sr_m_seq"}, int'(ms), int'(v.exp_m));
    @(negedge clk);
    chk({tag, "_idle_after"}, int'({busy, done, err, sr_dir}), 0);
  endtask

  initial begin
    int sh, dn, dc;
    rst = 1'b0; start = 1'b0; op = 2'b00; cmd_dir = 1'b0; cmd_cnt = 4'd0;
    cmd_fill = 1'b0; cmd_data = 4'b0000; q_load = 1'b0; q_init = 4'b0000;
    q = 4'b0000;

    //        op     dir   cnt    fill  data     init     exp_q    sh  err   chk_m exp_m
    vecs[0]  = '{2'b01, 1'b1, 4'd0,  1'b0, 4'b1011, 4'b0000, 4'b1011, 4, 1'b0, 1'b1, 4'b1011};
    vecs[1]  = '{2'b10, 1'b0, 4'd3,  1'b0, 4'b0000, 4'b1000, 4'b0001, 3, 1'b0, 1'b0, 4'b0000};
    vecs[2]  = '{2'b00, 1'b1, 4'd0,  1'b1, 4'b0000, 4'b0101, 4'b0101, 0, 1'b0, 1'b0, 4'b0000};
    vecs[3]  = '{2'b11, 1'b1, 4'd7,  1'b1, 4'b1111, 4'b1001, 4'b1001, 0, 1'b1, 1'b0, 4'b0000};
    vecs[4]  = '{2'b00, 1'b1, 4'd2,  1'b1, 4'b0000, 4'b0000, 4'b0011, 2, 1'b0, 1'b0, 4'b0000};
    vecs[5]  = '{2'b00, 1'b0, 4'd3,  1'b1, 4'b0000, 4'b0000, 4'b1110, 3, 1'b0, 1'b0, 4'b0000};
    vecs[6]  = '{2'b10, 1'b1, 4'd5,  1'b0, 4'b0000, 4'b1001, 4'b0011, 5, 1'b0, 1'b0, 4'b0000};
    vecs[7]  = '{2'b00, 1'b1, 4'd15, 1'b0, 4'b0000, 4'b1111, 4'b0000, 15, 1'b0, 1'b0, 4'b0000};
    vecs[8]  = '{2'b01, 1'b0, 4'd9,  1'b0, 4'b0110, 4'b1111, 4'b0110, 4, 1'b0, 1'b1, 4'b0110};
    vecs[9]  = '{2'b01, 1'b1, 4'd0,  1'b0, 4'b1100, 4'b0011, 4'b1100, 4, 1'b0, 1'b1, 4'b1100};
    vecs[10] = '{2'b10, 1'b1, 4'd0,  1'b0, 4'b0000, 4'b1010, 4'b1010, 0, 1'b0, 1'b0, 4'b0000};

    repeat (2) @(negedge clk);
    chk("reset_outputs", int'({busy, done, err, sr_en, sr_m, sr_dir}), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", int'({busy, done, err, sr_en, sr_m, sr_dir}), 0);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // start held high through a SHIFT of 5: one done, re-accept at edge k+7
    preset_q(4'b0000);
    op = 2'b00; cmd_dir = 1'b1; cmd_cnt = 4'd5; cmd_fill = 1'b1; start = 1'b1;
    @(posedge clk);
    sh = 0; dn = 0;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      if (sr_en) sh++;
      if (done) dn++;
      if (cyc == 7) chk("hold_idle_gap", int'({busy, sr_en}), 0);
    end
    chk("hold_first_shifts", sh, 5);
    chk("hold_first_dones", dn, 1);
    @(negedge clk);
    chk("hold_restart", int'({busy, sr_en}), 3);
    start = 1'b0;
    sh = 1; dc = 0;
    for (int cyc = 9; cyc <= 40 && dc == 0; cyc++) begin
      @(negedge clk);
      if (sr_en) sh++;
      if (done) dc = cyc;
    end
    chk("hold_second_shifts", sh, 5);
    chk("hold_second_done_cycle", dc, 13);
    chk("hold_q", int'(q), 15);

    // reset during the 2nd step of a LOAD
    preset_q(4'b0000);
    op = 2'b01; cmd_dir = 1'b1; cmd_data = 4'b1111; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_was_running", int'(sr_en), 1);
    rst = 1'b0;
    #1;
    chk("rst_mid_outputs", int'({busy, done, err, sr_en, sr_m, sr_dir}), 0);
    dn = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      if (done) dn++;
    end
    rst = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("rst_mid_no_done", dn, 0);
    run_vec('{2'b01, 1'b1, 4'd0, 1'b0, 4'b0110, 4'b1001, 4'b0110, 4, 1'b0, 1'b1, 4'b0110}, 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
